// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop RX synchroniser, mid-bit sampling via a baud down-counter, byte held until acked.
// Optional stop-bit error flag: define UART_RX_FRAME_ERR_EN to add the frame_err port.
module uart_rx #(
    parameter int CLKS_PER_BIT = 33,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RECEIVE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_rx_prev;
    logic        w_rx;
    logic [CW-1:0] r_baud;
    logic [3:0]  r_bit_cnt;
    logic [8:0]  r_shift;
    logic        r_rdy;
    logic        w_start;
    logic        w_sample;
    logic        w_abort;
    logic        w_done;

    assign w_rx    = r_sync2;
    assign rx_data = r_shift[7:0];
    assign rdy     = r_rdy;

    // r_rx_prev lets IDLE demand a genuine high->low edge, so a held-low line (break) cannot retrigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= RX;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        w_sample     = (r_state == S_RECEIVE) && (r_baud == '0);
        case (r_state)
            S_IDLE: begin
                if (!w_rx && r_rx_prev) begin
                    w_start      = 1'b1;
                    w_state_next = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (r_bit_cnt == 4'd10) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_sample && (r_bit_cnt == 4'd0) && w_rx) begin
                    // Line already back high at the start-bit midpoint: noise, not a frame.
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud    <= '0;
            r_bit_cnt <= 4'd0;
        end else if (w_start) begin
            r_baud    <= CW'(HALF_BIT);
            r_bit_cnt <= 4'd0;
        end else if (r_state == S_RECEIVE) begin
            if (w_abort || w_done) begin
                r_bit_cnt <= 4'd0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_sample) begin
                r_baud <= CW'(CLKS_PER_BIT - 1);
            end else begin
                r_baud <= r_baud - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 9'h000;
        end else if (w_sample) begin
            r_shift <= {w_rx, r_shift[8:1]};
        end
    end

    // Setting rdy outranks a same-cycle clr_rdy so a byte is never lost to an early ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else if (w_done) begin
            r_rdy <= 1'b1;
        end else if (w_start || clr_rdy) begin
            r_rdy <= 1'b0;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic r_frame_err;

    assign frame_err = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else if (w_done) begin
            r_frame_err <= ~r_shift[8];
        end else if (w_start || clr_rdy) begin
            r_frame_err <= 1'b0;
        end
    end
`else
    logic w_unused_stop;
    assign w_unused_stop = r_shift[8];
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of 8N1 frames plus hand sequences for latency, loopback,
// glitch, ack priority, break, new-start and mid-frame reset.
module tb_uart_rx;

    localparam int CPB  = 33;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .rx_data   (rx_data),
        .rdy       (rdy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Rising edges of rdy, to count delivered bytes.
    logic rdy_d = 1'b0;
    int   rdy_pulses = 0;
    always @(negedge clk) begin
        rdy_d <= rdy;
        if (rdy && !rdy_d) rdy_pulses <= rdy_pulses + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_rdy(input int budget, output int cyc, output logic ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rdy) ok = 1'b1;
        end
    endtask

    task automatic ack();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    logic [7:0] loop_bytes[3];
    int         cyc;
    logic       ok;
    int         p0;

    initial begin
        RX      = 1'b1;
        clr_rdy = 1'b0;
        rst_n   = 1'b0;
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_fe: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_fe: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_fe: 1'b0};
        vecs[3] = '{data: 8'h3C, stop: 1'b1, exp_fe: 1'b0};
        vecs[4] = '{data: 8'h7E, stop: 1'b0, exp_fe: 1'b1};
        vecs[5] = '{data: 8'h7E, stop: 1'b1, exp_fe: 1'b0};
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h5A;

        repeat (4) @(negedge clk);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_data", 32'(rx_data), 32'h00);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_fe", 32'(frame_err), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_rdy", 32'(rdy), 32'd0);

        // Latency of a single A5 frame measured from the RX falling edge.
        fork
            send_byte(8'hA5, 1'b1);
            wait_rdy(400, cyc, ok);
        join
        check("lat_seen", 32'(ok), 32'd1);
        check("lat_window", 32'(cyc >= 314 && cyc <= 322), 32'd1);
        check("lat_data", 32'(rx_data), 32'hA5);
        ack();
        check("lat_ack_rdy", 32'(rdy), 32'd0);
        repeat (20) @(negedge clk);

        // Table of frames, one ack after each.
        for (int v = 0; v < 6; v++) begin
            send_byte(vecs[v].data, vecs[v].stop);
            RX = 1'b1;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_rdy", v), 32'(rdy), 32'd1);
            check($sformatf("vec%0d_data", v), 32'(rx_data), 32'(vecs[v].data));
`ifdef UART_RX_FRAME_ERR_EN
            check($sformatf("vec%0d_fe", v), 32'(frame_err), 32'(vecs[v].exp_fe));
`endif
            ack();
            check($sformatf("vec%0d_ack", v), 32'(rdy), 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
            check($sformatf("vec%0d_fe_ack", v), 32'(frame_err), 32'd0);
`endif
            repeat (20) @(negedge clk);
        end

        // Back-to-back loopback frames, acked by a concurrent consumer.
        p0 = rdy_pulses;
        fork
            begin
                for (int k = 0; k < 3; k++) send_byte(loop_bytes[k], 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    int   c;
                    logic f;
                    wait_rdy(400, c, f);
                    check($sformatf("loop%0d_seen", k), 32'(f), 32'd1);
                    check($sformatf("loop%0d_data", k), 32'(rx_data), 32'(loop_bytes[k]));
                    ack();
                end
            end
        join
        repeat (5) @(negedge clk);
        check("loop_pulses", 32'(rdy_pulses - p0), 32'd3);

        // 5-clock glitch on the idle line.
        p0 = rdy_pulses;
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (80) @(negedge clk);
        check("glitch_rdy", 32'(rdy), 32'd0);
        check("glitch_pulses", 32'(rdy_pulses - p0), 32'd0);
        send_byte(8'h3C, 1'b1);
        check("glitch_next_data", 32'(rx_data), 32'h3C);
        check("glitch_next_rdy", 32'(rdy), 32'd1);
        ack();
        repeat (20) @(negedge clk);

        // clr_rdy held through the frame, including the cycle rdy is set.
        clr_rdy = 1'b1;
        fork
            send_byte(8'h96, 1'b1);
            begin
                wait_rdy(400, cyc, ok);
                clr_rdy = 1'b0;
            end
        join
        clr_rdy = 1'b0;
        check("setwins_seen", 32'(ok), 32'd1);
        check("setwins_rdy", 32'(rdy), 32'd1);
        check("setwins_data", 32'(rx_data), 32'h96);
        ack();
        check("clr_one_clk", 32'(rdy), 32'd0);
        ack();
        check("clr_when_low", 32'(rdy), 32'd0);
        repeat (20) @(negedge clk);

        // A new frame while rdy is still set drops rdy at its start.
        send_byte(8'h11, 1'b1);
        check("nostart_rdy", 32'(rdy), 32'd1);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (40) @(negedge clk);
                check("newstart_drops_rdy", 32'(rdy), 32'd0);
            end
        join
        check("newstart_rdy", 32'(rdy), 32'd1);
        check("newstart_data", 32'(rx_data), 32'h22);
        ack();
        repeat (20) @(negedge clk);

        // Break: line stays low after a frame; only one byte until it returns high.
        p0 = rdy_pulses;
        send_byte(8'h7E, 1'b0);
        repeat (150) @(negedge clk);
        check("break_pulses", 32'(rdy_pulses - p0), 32'd1);
        check("break_data", 32'(rx_data), 32'h7E);
        ack();
        RX = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        check("break_after_data", 32'(rx_data), 32'h3C);
        ack();
        repeat (20) @(negedge clk);

        // Reset in the middle of data bit 4 of C3.
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX = (8'hC3 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        RX = 1'b0;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        RX    = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_rdy", 32'(rdy), 32'd0);
        check("midrst_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        p0 = rdy_pulses;
        repeat (400) @(negedge clk);
        check("midrst_no_rdy", 32'(rdy_pulses - p0), 32'd0);
        send_byte(8'h81, 1'b1);
        check("midrst_next_rdy", 32'(rdy), 32'd1);
        check("midrst_next_data", 32'(rx_data), 32'h81);
        ack();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
